// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared enums, PWM constants and helpers for the key/LED sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_ALT   = 2'd2,
    MODE_COUNT = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    SPEED_NORMAL = 2'd0,
    SPEED_FAST   = 2'd1,
    SPEED_SLOW   = 2'd2
  } speed_t;

  localparam int PWM_PERIOD = 16;
  localparam int PWM_BITS   = $clog2(PWM_PERIOD);
  localparam logic [PWM_BITS-1:0] PWM_ON = PWM_BITS'(4);

  function automatic int unsigned speed_period(speed_t s, int unsigned tick);
    case (s)
      SPEED_FAST: return tick / 2;
      SPEED_SLOW: return 2 * tick;
      default:    return tick;
    endcase
  endfunction

  function automatic speed_t next_speed(speed_t s);
    case (s)
      SPEED_NORMAL: return SPEED_FAST;
      SPEED_FAST:   return SPEED_SLOW;
      default:      return SPEED_NORMAL;
    endcase
  endfunction

  function automatic mode_t next_mode(mode_t m);
    return mode_t'(m + 2'd1);
  endfunction

  function automatic logic [1:0] led_decode(mode_t m, logic [1:0] phase);
    case (m)
      MODE_BLINK: return phase[0] ? 2'b11 : 2'b00;
      MODE_ALT:   return phase[0] ? 2'b10 : 2'b01;
      MODE_COUNT: return phase;
      default:    return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/led_mode_sequencer_key_debounce.sv
// rtl/led_mode_sequencer_key_debounce.sv - key_debounce: synchroniser, debounce counter
// and single-cycle press pulse for one active-low key.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key,
  output logic press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_prev;
  logic [DW-1:0] cnt;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      stable      <= 1'b1;
      stable_prev <= 1'b1;
      cnt         <= '0;
      press       <= 1'b0;
    end else begin
      sync1       <= key;
      sync2       <= sync1;
      stable_prev <= stable;
      // Press is a registered falling edge of the accepted level.
      press       <= stable_prev & ~stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_mode_sequencer.sv
// rtl/led_mode_sequencer.sv - key-driven LED mode/speed sequencer top.
// Optional LED_DIM_EN adds a 25% duty PWM dimmer on lit LEDs.
module led_mode_sequencer
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_CYCLES     = 25000000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [1:0] keys,
  output logic [1:0] leds,
  output logic [1:0] mode,
  output logic [1:0] speed
);

  localparam int CW = $clog2(2 * TICK_CYCLES);

  logic          press0;
  logic          press1;
  logic          restart;
  logic          tick;
  logic [CW-1:0] last_cnt;
  logic [CW-1:0] tick_cnt;
  logic [1:0]    phase;
  logic [1:0]    pattern;
  mode_t         mode_q;
  speed_t        speed_q;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .key     (keys[0]),
    .press   (press0)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .key     (keys[1]),
    .press   (press1)
  );

  always_comb begin
    last_cnt = CW'(speed_period(speed_q, TICK_CYCLES) - 1);
    restart  = press0 | press1;
    tick     = (mode_q != MODE_OFF) && (tick_cnt == last_cnt);
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      mode_q   <= MODE_OFF;
      speed_q  <= SPEED_NORMAL;
      tick_cnt <= '0;
      phase    <= 2'd0;
      pattern  <= 2'b00;
    end else begin
      if (press0) mode_q <= next_mode(mode_q);
      if (press1) speed_q <= next_speed(speed_q);
      // A single restart covers simultaneous presses on both keys.
      if (restart || mode_q == MODE_OFF) begin
        tick_cnt <= '0;
        phase    <= 2'd0;
      end else if (tick) begin
        tick_cnt <= '0;
        phase    <= phase + 2'd1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
      pattern <= led_decode(mode_q, phase);
    end
  end

  assign mode  = mode_q;
  assign speed = speed_q;

`ifdef LED_DIM_EN
  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) pwm_cnt <= '0;
    else          pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign leds = pattern & {2{pwm_cnt < PWM_ON}};
`else
  assign leds = pattern;
`endif

endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb/tb_led_mode_sequencer.sv - directed self-checking bench for led_mode_sequencer.
module tb_led_mode_sequencer;

  logic       sys_clk;
  logic       sys_rst;
  logic [1:0] keys;
  logic [1:0] leds;
  logic [1:0] mode;
  logic [1:0] speed;

  int tests = 0;
  int fails = 0;

  led_mode_sequencer #(.DEBOUNCE_CYCLES(4), .TICK_CYCLES(8)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .keys    (keys),
    .leds    (leds),
    .mode    (mode),
    .speed   (speed)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Press keys in mask k; returns just after the edge where mode/speed update.
  task automatic press_key(input logic [1:0] k);
    keys = ~k;
    step(8);
    keys = 2'b11;
  endtask

  task automatic check_blink(input string tag, input int p, input int n);
    for (int i = 1; i <= n; i++) begin
      step(1);
      check(tag, leds, ((((i - 1) / p) % 2) != 0) ? 2'b11 : 2'b00);
    end
  endtask

  initial begin
    sys_rst = 1'b0;
    keys    = 2'b11;
    step(3);
    check("rst_leds", leds, 2'b00);
    check("rst_mode", mode, 2'd0);
    check("rst_speed", speed, 2'd0);
    sys_rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      check("idle_leds", leds, 2'b00);
      check("idle_mode", mode, 2'd0);
    end

    keys = 2'b10;
    for (int i = 1; i <= 32; i++) begin
      step(1);
      if (i == 10) keys = 2'b11;
      check("hold_mode", mode, (i >= 8) ? 2'd1 : 2'd0);
      check("hold_leds", leds, (i >= 17 && i <= 24) ? 2'b11 : 2'b00);
    end

    repeat (5) begin
      keys = 2'b10;
      step(3);
      keys = 2'b11;
      step(1);
    end
    step(12);
    check("glitch_mode", mode, 2'd1);
    check("glitch_speed", speed, 2'd0);

    press_key(2'b10);
    check("fast_speed", speed, 2'd1);
    check_blink("fast_leds", 4, 12);
    press_key(2'b10);
    check("slow_speed", speed, 2'd2);
    check_blink("slow_leds", 16, 34);
    press_key(2'b10);
    check("normal_speed", speed, 2'd0);
    check_blink("normal_leds", 8, 18);

    press_key(2'b01);
    step(10);
    press_key(2'b01);
    step(10);
    press_key(2'b10);
    step(10);
    press_key(2'b10);
    step(10);
    check("pre_both_mode", mode, 2'd3);
    check("pre_both_speed", speed, 2'd2);
    press_key(2'b11);
    check("both_mode", mode, 2'd0);
    check("both_speed", speed, 2'd0);
    for (int i = 1; i <= 12; i++) begin
      step(1);
      check("both_leds", leds, 2'b00);
    end

    press_key(2'b01);
    check("reblink_mode", mode, 2'd1);
    check_blink("reblink_leds", 8, 18);
    press_key(2'b01);
    step(10);
    press_key(2'b01);
    check("count_mode", mode, 2'd3);
    for (int i = 1; i <= 20; i++) begin
      step(1);
      check("count_leds", leds, 2'(((i - 1) / 8) % 4));
    end

    sys_rst = 1'b0;
    #2;
    check("async_leds", leds, 2'b00);
    check("async_mode", mode, 2'd0);
    check("async_speed", speed, 2'd0);
    keys = 2'b10;
    step(3);
    sys_rst = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      check("held_rst_mode", mode, (i >= 8) ? 2'd1 : 2'd0);
    end
    keys = 2'b11;
    step(10);
    check("held_rst_final", mode, 2'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
